// File: rtl/rf_pkg.sv
// Shared definitions for the regFile write-side loader: default widths, FSM state type and length type.
package rf_pkg;
    localparam int RF_PHIT_SIZE = 64;
    localparam int RF_ADDR_W    = 4;
    localparam int RF_DEPTH     = 16;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} ld_state_t;
    typedef logic [RF_ADDR_W:0] rf_len_t;
endpackage

// File: rtl/rf_stream_loader.sv
// Loads a valid/ready phit stream into consecutive regFile entries from a (base, len) command.
// 1-cycle write latency, 1 beat/cycle; stalls while s_valid is low, commands taken only in IDLE.
module rf_stream_loader
    import rf_pkg::*;
#(
    parameter int PHIT_SIZE = RF_PHIT_SIZE,
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int DEPTH     = RF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_base,
    input  logic [ADDR_W:0]      cmd_len,
    input  logic [PHIT_SIZE-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_last,
    output logic [PHIT_SIZE-1:0] rf_d_in,
    output logic [ADDR_W-1:0]    rf_wr_addr,
    output logic                 rf_wen,
    output logic                 busy,
    output logic                 done,
    output logic                 err_short,
    output logic                 err_long
);
    if (DEPTH != 2 ** ADDR_W) begin : g_bad_depth
        $error("rf_stream_loader: DEPTH must equal 2**ADDR_W");
    end

    ld_state_t          state;
    logic [ADDR_W-1:0]  base;
    logic [ADDR_W:0]    len;
    logic [ADDR_W:0]    beat_cnt;
    logic [ADDR_W:0]    len_m1;
    logic               last_slot;

    assign len_m1    = len - {{ADDR_W{1'b0}}, 1'b1};
    assign last_slot = (beat_cnt == len_m1);

    // rf_d_in/rf_wr_addr/rf_wen double as the one-beat write register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            rf_wen     <= 1'b0;
            rf_d_in    <= '0;
            rf_wr_addr <= '0;
            base       <= '0;
            len        <= '0;
            beat_cnt   <= '0;
        end else begin
            rf_wen <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        base      <= cmd_base;
                        len       <= cmd_len;
                        beat_cnt  <= '0;
                        err_short <= 1'b0;
                        err_long  <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        rf_wen     <= 1'b1;
                        rf_d_in    <= s_data;
                        rf_wr_addr <= base + beat_cnt[ADDR_W-1:0];
                        beat_cnt   <= beat_cnt + 1'b1;
                        if (last_slot && !s_last) begin
                            err_long <= 1'b1;
                            state    <= FLUSH;
                        end else if (last_slot || s_last) begin
                            err_short <= !last_slot;
                            state     <= DONE;
                            done      <= 1'b1;
                            s_ready   <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (s_valid && s_last) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        s_ready <= 1'b0;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_stream_loader.sv
// Randomized bench for rf_stream_loader with a behavioural regFile and a packet-level reference model.
module tb_rf_stream_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_base = '0;
    logic [4:0]  cmd_len = '0;
    logic [63:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last = 1'b0;
    logic [63:0] rf_d_in;
    logic [3:0]  rf_wr_addr;
    logic        rf_wen;
    logic        busy, done, err_short, err_long;

    rf_stream_loader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .rf_d_in(rf_d_in), .rf_wr_addr(rf_wr_addr), .rf_wen(rf_wen),
        .busy(busy), .done(done), .err_short(err_short), .err_long(err_long)
    );

    always #5 clk = ~clk;

    // regFile stand-in: write port only, never reset
    logic [63:0] mem [16];
    always @(posedge clk) if (rf_wen) mem[rf_wr_addr] <= rf_d_in;

    int wen_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (rf_wen) wen_cnt++;
        if (done) done_cnt++;
    end

    logic [63:0] exp_mem [16];
    bit          known [16];
    logic [63:0] pkt_q [$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic report();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_mem();
        for (int a = 0; a < 16; a++)
            if (known[a]) chk($sformatf("mem[%0d]", a), mem[a], exp_mem[a]);
    endtask

    task automatic model_write(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_mem[(b + i) % 16] = pkt_q[i];
            known[(b + i) % 16] = 1'b1;
        end
    endtask

    // Offer beats pkt_q[first..first+n-1]; returns on the negedge after the last handshake.
    task automatic send_beats(input int first, input int n, input int gap_pct);
        for (int i = first; i < first + n; i++) begin
            int t;
            while ($urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = pkt_q[i];
            s_last  = (i == pkt_q.size() - 1);
            t = 0;
            while (!s_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!s_ready) begin
                chk("s_ready_timeout", 64'd0, 64'd1);
                report();
            end
            @(posedge clk);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic issue_cmd(input logic [3:0] b, input logic [4:0] l);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_base  = b;
        cmd_len   = l;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] b, input logic [4:0] l, input int gap_pct);
        int wen0 = wen_cnt;
        int done0 = done_cnt;
        int pl = pkt_q.size();
        int nw = (int'(l) < pl) ? int'(l) : pl;
        issue_cmd(b, l);
        if (l == 0) begin
            s_valid = 1'b1;
            chk("len0_done", done, 1);
            chk("len0_s_ready", s_ready, 0);
            @(negedge clk);
            s_valid = 1'b0;
            nw = 0;
        end else begin
            send_beats(0, pl, gap_pct);
            chk("done_pulse", done, 1);
            chk("busy_in_done", busy, 1);
            chk("err_short", err_short, pl < int'(l));
            chk("err_long", err_long, pl > int'(l));
            @(negedge clk);
            chk("err_sticky", {err_short, err_long}, {pl < int'(l), pl > int'(l)});
        end
        chk("done_low", done, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        chk("wen_count", wen_cnt - wen0, nw);
        chk("done_count", done_cnt - done0, 1);
        model_write(b, nw);
        chk_mem();
    endtask

    task automatic fill_pkt(input int n, input logic [63:0] start, input bit rnd);
        pkt_q.delete();
        for (int i = 0; i < n; i++)
            pkt_q.push_back(rnd ? {$urandom, $urandom} : start + 64'(i));
    endtask

    initial begin
        for (int a = 0; a < 16; a++) known[a] = 1'b0;
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_outs", {s_ready, busy, done, rf_wen, err_short, err_long}, 6'd0);
        @(negedge clk);
        rst = 1'b0;

        fill_pkt(4, 64'hA0, 0); run_cmd(4'd2, 5'd4, 0);
        fill_pkt(4, 64'hB0, 0); run_cmd(4'd14, 5'd4, 30);
        fill_pkt(3, 64'hC0, 0); run_cmd(4'd6, 5'd5, 0);
        fill_pkt(4, 64'hD0, 0); run_cmd(4'd10, 5'd2, 20);
        pkt_q.delete();         run_cmd(4'd3, 5'd0, 0);
        fill_pkt(16, 0, 1);     run_cmd(4'd7, 5'd16, 0);

        // Reset in the middle of a load after two committed writes.
        fill_pkt(8, 0, 1);
        issue_cmd(4'd9, 5'd8);
        send_beats(0, 2, 40);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_outs", {s_ready, busy, done, rf_wen, err_short, err_long}, 6'd0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        model_write(4'd9, 2);
        @(negedge clk);
        rst = 1'b0;
        chk_mem();
        fill_pkt(5, 64'hE0, 0); run_cmd(4'd11, 5'd5, 0);

        for (int k = 0; k < 25; k++) begin
            logic [4:0] l = 5'($urandom_range(16));
            int pl = (l == 0) ? 0 : (($urandom_range(2) == 0) ? int'(l) : int'($urandom_range(1, 18)));
            fill_pkt(pl, 0, 1);
            run_cmd(4'($urandom_range(15)), l, 25);
        end
        report();
    end
endmodule
